// File: rtl/core_pkg.sv
// Shared core types: memory-arbiter FSM state and owner encodings, plus the
// reset program counter used by the core control FSM.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one
// transaction in flight. Define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_out_i,
    output logic              busy_o
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    arb_state_e        state, state_nxt;
    arb_owner_e        owner;
    logic              wr_q;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic [DATA_W-1:0] dm_resp;
    logic              gnt_if, gnt_dm, rv_if, rv_dm;
    logic              tie_to_if;

`ifdef MEM_ARB_RR_EN
    // Remembers which requester won the most recent grant, contested or not.
    logic last_dm;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_dm <= 1'b0;
        end else if (gnt_if || gnt_dm) begin
            last_dm <= gnt_dm;
        end
    end

    assign tie_to_if = last_dm;
`else
    assign tie_to_if = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_if    = 1'b0;
        gnt_dm    = 1'b0;
        rv_if     = 1'b0;
        rv_dm     = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req_i && dm_req_i) begin
                    gnt_if = tie_to_if;
                    gnt_dm = !tie_to_if;
                end else begin
                    gnt_if = if_req_i;
                    gnt_dm = dm_req_i;
                end
                if (if_req_i || dm_req_i) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cnt == LAT_LAST) begin
                    rv_if     = (owner == OWN_IF);
                    rv_dm     = (owner == OWN_DM);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A completed write reports zero data rather than whatever the memory drives.
    assign dm_resp = wr_q ? '0 : mem_out_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            owner      <= OWN_IF;
            wr_q       <= 1'b0;
            cnt        <= '0;
            mem_rw_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            mem_rw_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_dm) begin
                        owner      <= OWN_DM;
                        wr_q       <= dm_we_i;
                        mem_rw_o   <= dm_we_i;
                        mem_addr_o <= dm_addr_i;
                        mem_data_o <= dm_wdata_i;
                    end else if (gnt_if) begin
                        owner      <= OWN_IF;
                        wr_q       <= 1'b0;
                        mem_addr_o <= if_addr_i;
                    end
                end
                ISSUE:   cnt <= '0;
                WAIT:    cnt <= cnt + 3'd1;
                default: cnt <= '0;
            endcase
            if (rv_if) begin
                if_rdata_q <= mem_out_i;
            end
            if (rv_dm) begin
                dm_rdata_q <= dm_resp;
            end
        end
    end

    assign if_gnt_o    = gnt_if;
    assign dm_gnt_o    = gnt_dm;
    assign if_rvalid_o = rv_if;
    assign dm_rvalid_o = rv_dm;
    assign if_rdata_o  = rv_if ? mem_out_i : if_rdata_q;
    assign dm_rdata_o  = rv_dm ? dm_resp : dm_rdata_q;
    assign busy_o      = (state != IDLE);

endmodule
